// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - single memory port arbiter between fetch and data requesters
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_D    = 2'd2
    } own_t;

    localparam logic [3:0] STARVE_TH = 4'(STARVE_MAX);

    own_t       rsp_own;
    own_t       rsp_own_nxt;
    logic [3:0] starve_cnt;

    // Data has priority unless fetch has been denied long enough.
    always_comb begin
        if_gnt = 1'b0;
        d_gnt  = 1'b0;
        if (rst_n) begin
            if (if_req && (starve_cnt >= STARVE_TH)) begin
                if_gnt = 1'b1;
            end else if (d_req) begin
                d_gnt = 1'b1;
            end else if (if_req) begin
                if_gnt = 1'b1;
            end
        end
    end

    always_comb begin
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_wdata = '0;
        if (if_gnt) begin
            mem_addr = if_addr;
        end else if (d_gnt) begin
            mem_addr  = d_addr;
            mem_we    = d_we;
            mem_wdata = d_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= 4'd0;
        end else if (if_gnt || !if_req) begin
            starve_cnt <= 4'd0;
        end else if (starve_cnt != 4'hF) begin
            starve_cnt <= starve_cnt + 4'd1;
        end
    end

    // Response owner: remembers which requester the read data on the next cycle belongs to.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_own <= OWN_NONE;
        end else begin
            rsp_own <= rsp_own_nxt;
        end
    end

    always_comb begin
        rsp_own_nxt = OWN_NONE;
        if (if_gnt) begin
            rsp_own_nxt = OWN_IF;
        end else if (d_gnt && !d_we) begin
            rsp_own_nxt = OWN_D;
        end
    end

    always_comb begin
        if_rvalid = (rsp_own == OWN_IF);
        d_rvalid  = (rsp_own == OWN_D);
        if_rdata  = mem_rdata;
        d_rdata   = mem_rdata;
    end

endmodule
